// File: rtl/imu_pkt_pkg.sv
// Shared constants and the state encoding for the IMU sample framer.
// A packet is SYNC0, SYNC1, seq, x hi/lo, y hi/lo, z hi/lo, checksum.
package imu_pkt_pkg;

    localparam int unsigned PKT_LEN  = 10;
    localparam logic [3:0]  IDX_SEQ  = 4'd2;
    localparam logic [3:0]  IDX_CHK  = 4'd9;
    localparam logic [3:0]  IDX_LAST = 4'(PKT_LEN - 1);

    localparam logic [7:0]  SYNC0_DEFAULT = 8'hA5;
    localparam logic [7:0]  SYNC1_DEFAULT = 8'h5A;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        HOLD = 2'd2,
        WAIT = 2'd3
    } state_e;

endpackage

// File: rtl/imu_uart_framer.sv
// Packs one captured x/y/z IMU sample into a 10-byte packet and hands it
// byte by byte to uart_tx over its tx_start/tx_data/tx_busy interface.
module imu_uart_framer
    import imu_pkt_pkg::*;
#(
    parameter logic [7:0] SYNC0 = SYNC0_DEFAULT,
    parameter logic [7:0] SYNC1 = SYNC1_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [15:0] s_x,
    input  logic [15:0] s_y,
    input  logic [15:0] s_z,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_busy,
    output logic        pkt_done
);

    state_e      state_q, state_d;
    logic [3:0]  byte_idx_q, byte_idx_d;
    logic [7:0]  seq_q, seq_d;
    logic [7:0]  pkt_seq_q, pkt_seq_d;
    logic [15:0] x_q, x_d;
    logic [15:0] y_q, y_d;
    logic [15:0] z_q, z_d;
    logic [7:0]  chk_q, chk_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        s_ready_q, s_ready_d;
    logic [7:0]  cur_byte_s;
    logic        tx_start_s;
    logic        pkt_done_s;

    // Select the packet byte addressed by byte_idx from the captured copies
    always_comb begin
        cur_byte_s = 8'h00;
        case (byte_idx_q)
            4'd0:    cur_byte_s = SYNC0;
            4'd1:    cur_byte_s = SYNC1;
            IDX_SEQ: cur_byte_s = pkt_seq_q;
            4'd3:    cur_byte_s = x_q[15:8];
            4'd4:    cur_byte_s = x_q[7:0];
            4'd5:    cur_byte_s = y_q[15:8];
            4'd6:    cur_byte_s = y_q[7:0];
            4'd7:    cur_byte_s = z_q[15:8];
            4'd8:    cur_byte_s = z_q[7:0];
            IDX_CHK: cur_byte_s = chk_q;
            default: cur_byte_s = 8'h00;
        endcase
    end

    // tx_start and pkt_done must react to tx_busy in the same cycle, so they
    // are decoded from the registered state rather than delayed by a flop.
    assign tx_start_s = (state_q == ARM) && !tx_busy;
    assign pkt_done_s = (state_q == WAIT) && !tx_busy && (byte_idx_q == IDX_LAST);

    // Next-state and capture logic for the packet sequencer
    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        seq_d      = seq_q;
        pkt_seq_d  = pkt_seq_q;
        x_d        = x_q;
        y_d        = y_q;
        z_d        = z_q;
        chk_d      = chk_q;
        tx_data_d  = tx_data_q;
        case (state_q)
            IDLE: begin
                if (s_valid && s_ready_q) begin
                    x_d        = s_x;
                    y_d        = s_y;
                    z_d        = s_z;
                    pkt_seq_d  = seq_q;
                    chk_d      = seq_q + s_x[15:8] + s_x[7:0] + s_y[15:8]
                               + s_y[7:0] + s_z[15:8] + s_z[7:0];
                    seq_d      = seq_q + 8'd1;
                    byte_idx_d = 4'd0;
                    state_d    = ARM;
                end else begin
                    state_d = IDLE;
                end
            end
            ARM: begin
                if (!tx_busy) begin
                    tx_data_d = cur_byte_s;
                    state_d   = HOLD;
                end else begin
                    state_d = ARM;
                end
            end
            HOLD: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (!tx_busy) begin
                    if (byte_idx_q == IDX_LAST) begin
                        state_d = IDLE;
                    end else begin
                        byte_idx_d = byte_idx_q + 4'd1;
                        state_d    = ARM;
                    end
                end else begin
                    state_d = WAIT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        s_ready_d = (state_d == IDLE);
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            byte_idx_q <= 4'd0;
            seq_q      <= 8'h00;
            pkt_seq_q  <= 8'h00;
            x_q        <= 16'h0000;
            y_q        <= 16'h0000;
            z_q        <= 16'h0000;
            chk_q      <= 8'h00;
            tx_data_q  <= 8'h00;
            s_ready_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            seq_q      <= seq_d;
            pkt_seq_q  <= pkt_seq_d;
            x_q        <= x_d;
            y_q        <= y_d;
            z_q        <= z_d;
            chk_q      <= chk_d;
            tx_data_q  <= tx_data_d;
            s_ready_q  <= s_ready_d;
        end
    end

    // tx_data shows the new byte in its start cycle, then holds it
    assign tx_data  = tx_start_s ? cur_byte_s : tx_data_q;
    assign tx_start = tx_start_s;
    assign pkt_done = pkt_done_s;
    assign s_ready  = s_ready_q;

endmodule
